// File: rtl/cache_pkg.sv
// Shared widths, FSM states and address field helpers for the direct-mapped cache.
package cache_pkg;
  localparam int DEF_ADDR_W = 16;
  localparam int TAG_W      = DEF_ADDR_W - 12;
  localparam int IDX_W      = 10;
  localparam int OFF_W      = 2;
  localparam int LINE_W     = 128;
  localparam int WORD_W     = 32;
  localparam int NUM_LINES  = 1024;

  typedef enum logic [1:0] {IDLE, COMPARE, REFILL, WTHRU} state_t;

  // Index and word offset sit in the low 12 bits of every word address.
  function automatic logic [IDX_W-1:0] addr_idx(input logic [11:0] a);
    return a[11:2];
  endfunction

  function automatic logic [OFF_W-1:0] addr_off(input logic [11:0] a);
    return a[1:0];
  endfunction
endpackage

// File: rtl/cache_tag_memory.sv
// Tag array (not reset) plus valid vector (async clear); combinational read at idx.
module cache_tag_memory
  import cache_pkg::*;
#(
  parameter int TW = TAG_W
) (
  input  logic             globalclock,
  input  logic             reset,
  input  logic [IDX_W-1:0] idx,
  input  logic             wr_en,
  input  logic [TW-1:0]    wr_tag,
  input  logic             set_valid,
  output logic [TW-1:0]    tag,
  output logic             valid
);
  logic [TW-1:0]        tags [NUM_LINES];
  logic [NUM_LINES-1:0] valid_bits;

  always_ff @(posedge globalclock) begin
    if (wr_en) tags[idx] <= wr_tag;
  end

  always_ff @(posedge globalclock or posedge reset) begin
    if (reset) valid_bits <= '0;
    else if (wr_en && set_valid) valid_bits[idx] <= 1'b1;
  end

  assign tag   = tags[idx];
  assign valid = valid_bits[idx];
endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, read-allocate cache controller in front of a
// 1024x128 data memory; refills and write-throughs use a req/ack RAM handshake.
module cache_controller
  import cache_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              globalclock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [WORD_W-1:0] cpu_wdata,
  output logic [WORD_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_busy,
  output logic              cdm_wrEn,
  output logic [IDX_W-1:0]  cdm_address,
  output logic [LINE_W-1:0] cdm_inData,
  input  logic [LINE_W-1:0] cdm_outData,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ack
);
  localparam int TW = ADDR_W - 12;

  state_t              state, next_state;
  logic                req_we;
  logic [ADDR_W-1:0]   req_addr;
  logic [WORD_W-1:0]   req_wdata;
  logic [IDX_W-1:0]    idx;
  logic [OFF_W-1:0]    off;
  logic [TW-1:0]       tag;
  logic [TW-1:0]       stored_tag;
  logic                stored_valid;
  logic                hit;
  logic                tag_we;
  logic [WORD_W-1:0]   sel_word;
  logic [LINE_W-1:0]   merged_line;

  assign idx         = addr_idx(req_addr[11:0]);
  assign off         = addr_off(req_addr[11:0]);
  assign tag         = req_addr[ADDR_W-1:12];
  assign hit         = stored_valid && (stored_tag == tag);
  // Look up the incoming index in IDLE so the line is ready in COMPARE.
  assign cdm_address = (state == IDLE) ? addr_idx(cpu_addr[11:0]) : idx;
  assign cpu_busy    = (state != IDLE);

  cache_tag_memory #(.TW(TW)) u_tags (
    .globalclock (globalclock),
    .reset       (reset),
    .idx         (idx),
    .wr_en       (tag_we),
    .wr_tag      (tag),
    .set_valid   (1'b1),
    .tag         (stored_tag),
    .valid       (stored_valid)
  );

  always_comb begin
    sel_word    = cdm_outData[{off, 5'b0} +: WORD_W];
    merged_line = cdm_outData;
    merged_line[{off, 5'b0} +: WORD_W] = req_wdata;
  end

  always_ff @(posedge globalclock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && cpu_req) begin
        req_we    <= cpu_we;
        req_addr  <= cpu_addr;
        req_wdata <= cpu_wdata;
      end
    end
  end

  always_comb begin
    next_state = state;
    cpu_ready  = 1'b0;
    cpu_rdata  = '0;
    cdm_wrEn   = 1'b0;
    cdm_inData = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    tag_we     = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req) next_state = COMPARE;
      end
      COMPARE: begin
        if (req_we) begin
          // Write hits update the line in place; misses do not allocate.
          if (hit) begin
            cdm_wrEn   = 1'b1;
            cdm_inData = merged_line;
          end
          next_state = WTHRU;
        end else if (hit) begin
          cpu_ready  = 1'b1;
          cpu_rdata  = sel_word;
          next_state = IDLE;
        end else begin
          next_state = REFILL;
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        if (mem_ack) begin
          cdm_wrEn   = 1'b1;
          cdm_inData = mem_rdata;
          tag_we     = 1'b1;
          next_state = COMPARE;
        end
      end
      WTHRU: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = req_addr;
        mem_wdata = req_wdata;
        if (mem_ack) begin
          cpu_ready  = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench: data-memory and RAM models around the controller, a directed
// vector table, a reset-during-refill sequence and random traffic against a cache model.
module tb_cache_controller;
  logic         globalclock = 1'b0;
  logic         reset;
  logic         cpu_req, cpu_we;
  logic [15:0]  cpu_addr;
  logic [31:0]  cpu_wdata, cpu_rdata;
  logic         cpu_ready, cpu_busy;
  logic         cdm_wrEn;
  logic [9:0]   cdm_address;
  logic [127:0] cdm_inData, cdm_outData;
  logic         mem_req, mem_we, mem_ack;
  logic [15:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [127:0] mem_rdata;

  int vectors = 0;
  int miscompares = 0;
  logic ack_hold = 1'b0;

  always #5 globalclock = ~globalclock;

  cache_controller #(.ADDR_W(16)) dut (
    .globalclock(globalclock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_busy(cpu_busy),
    .cdm_wrEn(cdm_wrEn), .cdm_address(cdm_address), .cdm_inData(cdm_inData),
    .cdm_outData(cdm_outData),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // Data memory: combinational read, write on cdm_wrEn.
  logic [127:0] dm [1024];
  initial for (int i = 0; i < 1024; i++) dm[i] = '0;
  always @(posedge globalclock) if (cdm_wrEn) dm[cdm_address] <= cdm_inData;
  assign cdm_outData = dm[cdm_address];

  // Main RAM seen by the DUT, and the reference model's own copy.
  logic [31:0] ram [int];
  logic [31:0] ref_mem [int];
  bit          ref_valid [1024];
  logic [3:0]  ref_tag [1024];

  function automatic logic [31:0] dflt(input logic [15:0] a);
    return {a, ~a};
  endfunction
  function automatic logic [31:0] ram_rd(input logic [15:0] a);
    return ram.exists(int'(a)) ? ram[int'(a)] : dflt(a);
  endfunction
  function automatic logic [31:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
  endfunction

  // RAM responder: random wait, then a one-cycle ack.
  initial begin
    int wait_cnt;
    mem_ack = 1'b0;
    mem_rdata = '0;
    wait_cnt = 1;
    forever begin
      @(negedge globalclock);
      mem_ack = 1'b0;
      if (mem_req && !reset && !ack_hold) begin
        if (wait_cnt == 0) begin
          mem_ack = 1'b1;
          if (mem_we) ram[int'(mem_addr)] = mem_wdata;
          else mem_rdata = {ram_rd(mem_addr + 16'd3), ram_rd(mem_addr + 16'd2),
                            ram_rd(mem_addr + 16'd1), ram_rd(mem_addr)};
          wait_cnt = $urandom_range(0, 3);
        end else wait_cnt--;
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Cache behaviour at transaction level: expected refills, data-memory writes and data.
  task automatic model_txn(input logic we, input logic [15:0] a, input logic [31:0] wd,
                           output logic [31:0] ed, output int eref, output int ecdm,
                           output int ewt);
    int  i;
    bit  h;
    i = int'(a[11:2]);
    h = ref_valid[i] && (ref_tag[i] == a[15:12]);
    ed = '0;
    if (we) begin
      eref = 0; ecdm = h ? 1 : 0; ewt = 1;
      ref_mem[int'(a)] = wd;
    end else begin
      eref = h ? 0 : 1; ecdm = eref; ewt = 0;
      ref_valid[i] = 1'b1;
      ref_tag[i] = a[15:12];
      ed = ref_rd(a);
    end
  endtask

  // One CPU transaction; junk requests are held on cpu_req while busy.
  task automatic run_txn(input logic we, input logic [15:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output int lat, output int nref,
                         output int nwt, output int ncdm, output logic [15:0] maddr,
                         output logic [9:0] caddr, output bit busy_ok, output bit done);
    rd = '0; lat = 0; nref = 0; nwt = 0; ncdm = 0; maddr = '0; caddr = '0;
    busy_ok = 1'b1; done = 1'b0;
    @(negedge globalclock);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    @(posedge globalclock);
    #1;
    cpu_we = 1'b1; cpu_addr = 16'($urandom); cpu_wdata = $urandom;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge globalclock);
      #1;
      lat++;
      if (!cpu_busy) busy_ok = 1'b0;
      if (cdm_wrEn) begin ncdm++; caddr = cdm_address; end
      if (mem_req && mem_ack) begin
        if (mem_we) nwt++; else nref++;
        maddr = mem_addr;
      end
      if (cpu_ready) begin rd = cpu_rdata; done = 1'b1; end
    end
    cpu_req = 1'b0;
  endtask

  task automatic do_check(input string tn, input logic we, input logic [15:0] a,
                          input logic [31:0] wd, input logic [31:0] ed, input int eref,
                          input int ecdm, input int ewt);
    logic [31:0] rd; int lat, nref, nwt, ncdm; logic [15:0] maddr; logic [9:0] caddr;
    bit busy_ok, done;
    run_txn(we, a, wd, rd, lat, nref, nwt, ncdm, maddr, caddr, busy_ok, done);
    chk({tn, " completed"}, 128'(done), 128'(1));
    chk({tn, " refills"}, 128'(nref), 128'(eref));
    chk({tn, " write-throughs"}, 128'(nwt), 128'(ewt));
    chk({tn, " cdm writes"}, 128'(ncdm), 128'(ecdm));
    chk({tn, " busy"}, 128'(busy_ok), 128'(1));
    if (!we) chk({tn, " rdata"}, 128'(rd), 128'(ed));
    if (!we && eref == 0) chk({tn, " hit latency"}, 128'(lat), 128'(1));
    if (nref + nwt > 0)
      chk({tn, " mem_addr"}, 128'(maddr), 128'(we ? a : {a[15:2], 2'b00}));
    if (ncdm > 0) chk({tn, " cdm_address"}, 128'(caddr), 128'(a[11:2]));
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_refill;
    int          exp_cdm;
    int          exp_wthru;
  } vec_t;

  initial begin
    vec_t tbl [9];
    logic [31:0] ed; int eref, ecdm, ewt;
    logic [127:0] snap;
    logic [9:0] pool [3];
    logic [15:0] a;
    bit seen;

    tbl[0] = '{1'b0, 16'h1234, 32'h0,        32'hAAAAAAAA, 1, 1, 0};
    tbl[1] = '{1'b0, 16'h1235, 32'h0,        32'hBBBBBBBB, 0, 0, 0};
    tbl[2] = '{1'b1, 16'h1236, 32'hCAFEF00D, 32'h0,        0, 1, 1};
    tbl[3] = '{1'b0, 16'h1236, 32'h0,        32'hCAFEF00D, 0, 0, 0};
    tbl[4] = '{1'b1, 16'h5000, 32'h11112222, 32'h0,        0, 0, 1};
    tbl[5] = '{1'b0, 16'h5000, 32'h0,        32'h11112222, 1, 1, 0};
    tbl[6] = '{1'b0, 16'h5234, 32'h0,        32'h5234ADCB, 1, 1, 0};
    tbl[7] = '{1'b0, 16'h1234, 32'h0,        32'hAAAAAAAA, 1, 1, 0};
    tbl[8] = '{1'b0, 16'h1236, 32'h0,        32'hCAFEF00D, 0, 0, 0};

    ram[32'h1234] = 32'hAAAAAAAA; ram[32'h1235] = 32'hBBBBBBBB;
    ram[32'h1236] = 32'hCCCCCCCC; ram[32'h1237] = 32'hDDDDDDDD;
    ref_mem[32'h1234] = 32'hAAAAAAAA; ref_mem[32'h1235] = 32'hBBBBBBBB;
    ref_mem[32'h1236] = 32'hCCCCCCCC; ref_mem[32'h1237] = 32'hDDDDDDDD;
    for (int i = 0; i < 1024; i++) begin ref_valid[i] = 1'b0; ref_tag[i] = '0; end

    reset = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = '1;
    repeat (3) @(negedge globalclock);
    #1;
    chk("reset cpu_busy", 128'(cpu_busy), 128'(0));
    chk("reset cpu_ready", 128'(cpu_ready), 128'(0));
    chk("reset mem_req", 128'(mem_req), 128'(0));
    chk("reset cdm_wrEn", 128'(cdm_wrEn), 128'(0));
    chk("reset outputs", {cpu_rdata, mem_we, mem_addr, mem_wdata}, 128'(0));
    chk("reset cdm_inData", cdm_inData, 128'(0));
    cpu_req = 1'b0;
    @(negedge globalclock);
    reset = 1'b0;

    for (int v = 0; v < 9; v++) begin
      model_txn(tbl[v].we, tbl[v].addr, tbl[v].wdata, ed, eref, ecdm, ewt);
      do_check($sformatf("vec%0d", v), tbl[v].we, tbl[v].addr, tbl[v].wdata,
               tbl[v].exp_rdata, tbl[v].exp_refill, tbl[v].exp_cdm, tbl[v].exp_wthru);
    end

    // Reset while a refill is outstanding.
    ack_hold = 1'b1;
    snap = dm[10'h08D];
    @(negedge globalclock);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h7234;
    @(posedge globalclock);
    #1 cpu_req = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge globalclock);
      #1 if (mem_req) seen = 1'b1;
    end
    chk("midreset refill started", 128'(seen), 128'(1));
    #2 reset = 1'b1;
    #1;
    chk("midreset mem_req", 128'(mem_req), 128'(0));
    chk("midreset cpu_busy", 128'(cpu_busy), 128'(0));
    chk("midreset cdm_wrEn", 128'(cdm_wrEn), 128'(0));
    @(negedge globalclock);
    reset = 1'b0;
    ack_hold = 1'b0;
    chk("midreset line untouched", dm[10'h08D], snap);
    for (int i = 0; i < 1024; i++) ref_valid[i] = 1'b0;
    model_txn(1'b0, 16'h1234, 32'h0, ed, eref, ecdm, ewt);
    do_check("post-reset reread", 1'b0, 16'h1234, 32'h0, 32'hAAAAAAAA, 1, 1, 0);

    // Random traffic over a few indices and tags so hits, misses and conflicts mix.
    pool[0] = 10'h08D; pool[1] = 10'h001; pool[2] = 10'h3FF;
    for (int t = 0; t < 200; t++) begin
      logic we; logic [31:0] wd;
      a  = {4'($urandom_range(0, 3)), pool[$urandom_range(0, 2)], 2'($urandom_range(0, 3))};
      we = ($urandom_range(0, 9) < 3);
      wd = $urandom;
      model_txn(we, a, wd, ed, eref, ecdm, ewt);
      do_check($sformatf("rnd%0d", t), we, a, wd, ed, eref, ecdm, ewt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Direct-mapped, write-through, read-allocate cache controller placed directly upstream of the cache data memory, whose array is 1024 lines x 128 bits with a combinational read and a write on wrEn.
- Accepts 32-bit word requests from the CPU side and holds the tag/valid state.
- Drives the data memory's address, write enable and write data.
- Performs line refills and write-through transfers to main RAM over a req/ack handshake.

Parameters:
- ADDR_W, 16, CPU word-address width. Tag = ADDR_W-12 bits, index = 10 bits, word offset = 2 bits.
- WORD_W, 32, CPU data word width. Fixed at 128/4.

Ports:
- globalclock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  request strobe; sampled in IDLE only.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  word address {tag, index, offset}.
- cpu_wdata  in  32  write data.
- cpu_rdata  out  32  read data; valid while cpu_ready = 1.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_busy  out  1  high in every state except IDLE.
- cdm_wrEn  out  1  data-memory write enable.
- cdm_address  out  10  data-memory line index.
- cdm_inData  out  128  data-memory write line.
- cdm_outData  in  128  data-memory combinational read line.
- mem_req  out  1  RAM request, held until ack.
- mem_we  out  1  1 = single-word write, 0 = line read.
- mem_addr  out  ADDR_W  word address; offset bits forced to 00 for line reads.
- mem_wdata  out  32  write word.
- mem_rdata  in  128  refill line; valid with mem_ack.
- mem_ack  in  1  one-cycle completion from RAM.

Behaviour:
- Reset (async, active-high):
  - FSM to IDLE; all 1024 valid bits cleared.
  - Outputs zero: cpu_ready, cpu_busy, cpu_rdata, cdm_wrEn, mem_req, mem_we, mem_addr, mem_wdata, cdm_inData.
  - Tag array contents are not reset.
  - Reset mid-operation abandons the request, drops mem_req immediately and issues no data-memory write.
- Request latch: in IDLE with cpu_req=1, latch we/addr/wdata and go to COMPARE. cdm_address = cpu_addr index in IDLE and the latched index otherwise.
- Hit definition: hit = valid[idx] && tag[idx]==latched tag. The selected word is cdm_outData[32*off +: 32].
- COMPARE, read hit: cpu_ready=1, cpu_rdata = selected word, go to IDLE. Latency from cpu_req sample to cpu_ready is 1 cycle.
- COMPARE, read miss: go to REFILL.
- COMPARE, write: if hit, cdm_wrEn=1 for that cycle with cdm_inData = cdm_outData with word off replaced by the latched wdata. On a miss there is no allocate. Go to WTHRU in both cases.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr = {tag, idx, 2'b00}.
  - On mem_ack: cdm_wrEn=1, cdm_inData=mem_rdata, tag[idx]<=tag, valid[idx]<=1, mem_req drops, go to COMPARE.
  - The re-lookup then hits.
  - Conflict misses overwrite the line silently; no writeback is needed because the cache is write-through.
- WTHRU:
  - mem_req=1, mem_we=1, mem_addr=latched addr, mem_wdata=latched wdata.
  - On mem_ack: cpu_ready=1, go to IDLE.
- mem_req deasserts in the cycle after mem_ack is sampled. mem_ack in IDLE/COMPARE is ignored.
- cpu_req while cpu_busy=1 is ignored; there is no queueing. cpu_ready and cpu_req may coincide only in IDLE's next cycle.
- cdm_wrEn is never high outside COMPARE (write hit) or the REFILL ack cycle.
- Arithmetic: no arithmetic beyond field slicing; all widths are exact, with no truncation.

Decomposition:
- Package cache_pkg:
  - TAG_W, IDX_W=10, OFF_W=2, LINE_W=128, NUM_LINES=1024.
  - State enum: IDLE, COMPARE, REFILL, WTHRU.
  - Field-extract functions.
- Sub-module cache_tag_memory:
  - 1024 x TAG_W tag array plus a 1024-bit valid vector with async clear.
  - Write port (idx, tag, set_valid); combinational read of tag/valid at idx.

Test Plan:
- Reset, then read 0x1234 with RAM returning line 0xDDDD..._CCCC..._BBBB..._AAAAAAAA -> REFILL with mem_addr=0x1234 & ~3 = 0x1234, cdm write at idx 0x08D. Then cpu_ready with cpu_rdata = word 0 (off=0) = 0xAAAAAAAA.
- Repeat read 0x1235 -> no mem_req, cpu_ready exactly 1 cycle after request, cpu_rdata = word 1 = 0xBBBBBBBB.
- Write 0x1236 data 0xCAFEF00D (hit) -> cdm_wrEn 1 cycle with word 2 replaced. Then mem_we=1, mem_addr=0x1236, and cpu_ready after mem_ack. A following read of 0x1236 returns 0xCAFEF00D with no mem_req.
- Write miss to 0x5000 -> no cdm_wrEn and valid[0x000] unchanged. A subsequent read of 0x5000 misses and refills.
- Conflict: read 0x1234 then 0x5234 (same idx, different tag) -> second read refills. Re-reading 0x1234 misses again.
- Assert reset during REFILL before mem_ack -> mem_req falls immediately, valid cleared, no cdm write. A cpu_req issued while busy in any state is never serviced.
